// File: rtl/rx_frame_fifo_if.sv
// Voted-byte input, framed byte output and status counters of rx_frame_fifo.
interface rx_frame_fifo_if #(parameter int LEN_AW = 4);
    logic            in_en;
    logic [7:0]      in_data;
    logic            in_loss;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_last;
    logic            out_ready;
    logic [15:0]     frames_ok;
    logic [15:0]     frames_dropped;
    logic [15:0]     loss_events;
    logic [LEN_AW:0] frames_pending;

    modport master (
        output in_en, in_data, in_loss, out_ready,
        input  out_valid, out_data, out_last,
        input  frames_ok, frames_dropped, loss_events, frames_pending
    );

    modport slave (
        input  in_en, in_data, in_loss, out_ready,
        output out_valid, out_data, out_last,
        output frames_ok, frames_dropped, loss_events, frames_pending
    );
endinterface

// File: rtl/rx_frame_fifo.sv
// Frame store: commits or drops whole voted frames, replays them as a valid/ready byte stream.
// out_valid rises two cycles after the commit edge; out_data/out_last are held while out_ready is low.

// Generic FIFO with combinational read of the head entry; the caller never pushes when full.
module fifo #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wp, rp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
endmodule

module rx_frame_fifo #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_AW     = 4,
    parameter int MIN_LEN    = 1,
    parameter int MAX_LEN    = 2048
) (
    input logic            clk125MHz,
    input logic            reset,
    rx_frame_fifo_if.slave bus
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] RAM_BYTES = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LEN_AW:0]     LEN_SLOTS = {1'b1, {LEN_AW{1'b0}}};
    localparam logic [15:0]         MIN_L     = 16'(MIN_LEN);
    localparam logic [15:0]         MAX_L     = 16'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, SHOW} state_t;

    logic [7:0]            ram [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, wr_commit, rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [15:0]           len, rem, lf_dout;
    logic                  armed, in_run, bad;
    logic                  capture, frame_end, ram_full, too_long, do_write, commit;
    logic                  lf_pop, lf_empty, rd_hs, last_hs;
    logic                  loss_q, loss_q2;
    logic [15:0]           frames_ok, frames_dropped, loss_events;
    logic [LEN_AW:0]       pending;
    state_t                state;
    logic                  out_valid, out_last;
    logic [7:0]            out_data;

    assign capture   = armed & bus.in_en;
    assign frame_end = armed & in_run & ~bus.in_en;
    assign ram_full  = (wr_ptr - rd_ptr) == RAM_BYTES;
    assign too_long  = (len >= MAX_L);
    assign do_write  = capture & ~bad & ~ram_full & ~too_long;
    // The frame being read still holds a slot, so pending never exceeds 2**LEN_AW.
    assign commit    = frame_end & ~bad & (len >= MIN_L) & (pending != LEN_SLOTS);
    assign rd_hs     = out_valid & bus.out_ready;
    assign last_hs   = rd_hs & out_last;
    assign lf_pop    = (state == IDLE) & ~lf_empty;
    assign rd_addr   = rd_ptr[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-1){1'b0}}, rd_hs};

    fifo #(.W(16), .AW(LEN_AW)) u_len_fifo (
        .clk   (clk125MHz),
        .rst   (reset),
        .push  (commit),
        .din   (len),
        .pop   (lf_pop),
        .dout  (lf_dout),
        .empty (lf_empty)
    );

    always_ff @(posedge clk125MHz) begin
        if (do_write) ram[wr_ptr[ADDR_WIDTH-1:0]] <= bus.in_data;
    end

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            armed          <= 1'b0;
            in_run         <= 1'b0;
            wr_ptr         <= '0;
            wr_commit      <= '0;
            len            <= '0;
            bad            <= 1'b0;
            frames_ok      <= '0;
            frames_dropped <= '0;
            loss_q         <= 1'b0;
            loss_q2        <= 1'b0;
            loss_events    <= '0;
            pending        <= '0;
        end else begin
            if (!bus.in_en) armed <= 1'b1;
            in_run <= capture;
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (capture) begin
                if (len != 16'hFFFF) len <= len + 16'd1;
                if (ram_full || too_long) bad <= 1'b1;
            end
            if (frame_end) begin
                len <= '0;
                bad <= 1'b0;
                if (commit) begin
                    wr_commit <= wr_ptr;
                    if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
                end else begin
                    wr_ptr <= wr_commit;
                    if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
                end
            end
            if (commit && !last_hs)      pending <= pending + 1'b1;
            else if (last_hs && !commit) pending <= pending - 1'b1;
            loss_q  <= bus.in_loss;
            loss_q2 <= loss_q;
            if (loss_q && !loss_q2 && loss_events != 16'hFFFF) loss_events <= loss_events + 16'd1;
        end
    end

    // Reader; the RAM address looks one byte ahead on a handshake so bursts run at one byte per cycle.
    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_data <= ram[rd_addr];
            case (state)
                IDLE: begin
                    if (!lf_empty) begin
                        rem   <= lf_dout;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state     <= SHOW;
                    out_valid <= 1'b1;
                    out_last  <= (rem == 16'd1);
                end
                SHOW: begin
                    if (bus.out_ready) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        rem    <= rem - 16'd1;
                        if (rem == 16'd1) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_last <= (rem == 16'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid      = out_valid;
    assign bus.out_data       = out_data;
    assign bus.out_last       = out_last;
    assign bus.frames_ok      = frames_ok;
    assign bus.frames_dropped = frames_dropped;
    assign bus.loss_events    = loss_events;
    assign bus.frames_pending = pending;
endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo: four parameterisations, one active at a time, checked by a byte scoreboard.
module tb_rx_frame_fifo;
    logic       clk, rst, en, loss, rdy, tog, tog_en;
    logic [7:0] dat;
    logic       rdy_eff;
    int         cur;
    int         checks, errors;
    logic [8:0] expq [$];
    logic       holding;
    logic [7:0] held_d;
    logic       held_l;

    logic        ov   [4];
    logic [7:0]  od   [4];
    logic        ol   [4];
    logic [15:0] fok  [4];
    logic [15:0] fdr  [4];
    logic [15:0] lev  [4];
    logic [15:0] pend [4];

    rx_frame_fifo_if #(.LEN_AW(4)) if0 ();
    rx_frame_fifo_if #(.LEN_AW(4)) if1 ();
    rx_frame_fifo_if #(.LEN_AW(4)) if2 ();
    rx_frame_fifo_if #(.LEN_AW(1)) if3 ();

    rx_frame_fifo #(.ADDR_WIDTH(12), .LEN_AW(4), .MIN_LEN(1), .MAX_LEN(2048)) u_main  (.clk125MHz(clk), .reset(rst), .bus(if0));
    rx_frame_fifo #(.ADDR_WIDTH(12), .LEN_AW(4), .MIN_LEN(1), .MAX_LEN(16))   u_max16 (.clk125MHz(clk), .reset(rst), .bus(if1));
    rx_frame_fifo #(.ADDR_WIDTH(6),  .LEN_AW(4), .MIN_LEN(1), .MAX_LEN(64))   u_small (.clk125MHz(clk), .reset(rst), .bus(if2));
    rx_frame_fifo #(.ADDR_WIDTH(12), .LEN_AW(1), .MIN_LEN(1), .MAX_LEN(2048)) u_lf    (.clk125MHz(clk), .reset(rst), .bus(if3));

    assign rdy_eff = tog_en ? tog : rdy;

    assign if0.in_en = en && (cur == 0);   assign if0.in_data = dat;
    assign if1.in_en = en && (cur == 1);   assign if1.in_data = dat;
    assign if2.in_en = en && (cur == 2);   assign if2.in_data = dat;
    assign if3.in_en = en && (cur == 3);   assign if3.in_data = dat;
    assign if0.in_loss = loss && (cur == 0);
    assign if1.in_loss = 1'b0;
    assign if2.in_loss = 1'b0;
    assign if3.in_loss = 1'b0;
    assign if0.out_ready = (cur == 0) && rdy_eff;
    assign if1.out_ready = (cur == 1) && rdy_eff;
    assign if2.out_ready = (cur == 2) && rdy_eff;
    assign if3.out_ready = (cur == 3) && rdy_eff;

    assign ov[0] = if0.out_valid; assign od[0] = if0.out_data; assign ol[0] = if0.out_last;
    assign ov[1] = if1.out_valid; assign od[1] = if1.out_data; assign ol[1] = if1.out_last;
    assign ov[2] = if2.out_valid; assign od[2] = if2.out_data; assign ol[2] = if2.out_last;
    assign ov[3] = if3.out_valid; assign od[3] = if3.out_data; assign ol[3] = if3.out_last;
    assign fok[0] = if0.frames_ok; assign fdr[0] = if0.frames_dropped; assign lev[0] = if0.loss_events;
    assign fok[1] = if1.frames_ok; assign fdr[1] = if1.frames_dropped; assign lev[1] = if1.loss_events;
    assign fok[2] = if2.frames_ok; assign fdr[2] = if2.frames_dropped; assign lev[2] = if2.loss_events;
    assign fok[3] = if3.frames_ok; assign fdr[3] = if3.frames_dropped; assign lev[3] = if3.loss_events;
    assign pend[0] = 16'(if0.frames_pending);
    assign pend[1] = 16'(if1.frames_pending);
    assign pend[2] = 16'(if2.frames_pending);
    assign pend[3] = 16'(if3.frames_pending);

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial tog = 1'b0;
    always begin
        @(posedge clk);
        #1;
        tog = ~tog;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Output monitor: every accepted byte is popped from the scoreboard; stalled bytes must not move.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && ov[cur]) begin
            if (holding) begin
                check("hold_data", 32'(od[cur]), 32'(held_d));
                check("hold_last", 32'(ol[cur]), 32'(held_l));
            end
            if (rdy_eff) begin
                holding = 1'b0;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, required no output", od[cur]);
                end else begin
                    e = expq.pop_front();
                    check("out_data", 32'(od[cur]), 32'(e[7:0]));
                    check("out_last", 32'(ol[cur]), 32'(e[8]));
                end
            end else begin
                holding = 1'b1;
                held_d  = od[cur];
                held_l  = ol[cur];
            end
        end else begin
            holding = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input int base, input bit exp_ok);
        for (int i = 0; i < n; i++) begin
            en  = 1'b1;
            dat = 8'(base + i);
            if (exp_ok) expq.push_back({(i == n - 1), dat});
            tick();
        end
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid", 32'(ov[cur]), 0);
        check("rst_out_data", 32'(od[cur]), 0);
        check("rst_out_last", 32'(ol[cur]), 0);
        check("rst_frames_ok", 32'(fok[cur]), 0);
        check("rst_frames_dropped", 32'(fdr[cur]), 0);
        check("rst_loss_events", 32'(lev[cur]), 0);
        check("rst_frames_pending", 32'(pend[cur]), 0);
        expq.delete();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        check("drain_left", 32'(expq.size()), 0);
    endtask

    task automatic finish_segment();
        rdy = 1'b1;
        drain();
        tick();
        tick();
        check("pending_end", 32'(pend[cur]), 0);
    endtask

    typedef struct {
        int inst;
        bit rdy;
        int len;
        int base;
        bit exp_commit;
        bit drain_first;
        bit lat;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok_m, drop_m, k;
        // inst 0: default, 1: MAX_LEN=16, 2: ADDR_WIDTH=6, 3: LEN_AW=1
        vecs[0]  = '{0, 1, 64, 'h00, 1, 0, 1};
        vecs[1]  = '{0, 1,  1, 'h77, 1, 1, 1};
        vecs[2]  = '{0, 1,  3, 'hF0, 1, 0, 0};
        vecs[3]  = '{1, 1, 17, 'h10, 0, 0, 0};
        vecs[4]  = '{1, 1, 16, 'h30, 1, 0, 0};
        vecs[5]  = '{2, 0, 40, 'h80, 1, 0, 0};
        vecs[6]  = '{2, 0, 40, 'hC0, 0, 0, 0};
        vecs[7]  = '{2, 1, 40, 'h20, 1, 1, 0};
        vecs[8]  = '{3, 0,  4, 'h01, 1, 0, 0};
        vecs[9]  = '{3, 0,  4, 'h11, 1, 0, 0};
        vecs[10] = '{3, 0,  4, 'h21, 0, 0, 0};

        checks = 0; errors = 0;
        rst = 1'b1; en = 1'b0; dat = '0; loss = 1'b0; rdy = 1'b1; tog_en = 1'b0;
        holding = 1'b0; held_d = '0; held_l = 1'b0;
        cur = 0;
        do_reset();
        ok_m = 0; drop_m = 0;

        for (int r = 0; r < NV; r++) begin
            if (vecs[r].inst != cur) begin
                finish_segment();
                cur = vecs[r].inst;
                do_reset();
                ok_m = 0; drop_m = 0;
            end
            rdy = vecs[r].rdy;
            if (vecs[r].drain_first) drain();
            send_frame(vecs[r].len, vecs[r].base, vecs[r].exp_commit);
            tick();
            if (vecs[r].exp_commit) ok_m++; else drop_m++;
            check("frames_ok", 32'(fok[cur]), 32'(ok_m));
            check("frames_dropped", 32'(fdr[cur]), 32'(drop_m));
            if (vecs[r].lat) begin
                k = 0;
                while (!ov[cur] && k < 20) begin
                    tick();
                    k++;
                end
                check("first_valid_edge", 32'(k + 1), 3);
            end
        end
        check("lf_pending", 32'(pend[3]), 2);
        finish_segment();

        // Two frames with a one-cycle gap, out_ready toggling every cycle.
        cur = 0;
        do_reset();
        tog_en = 1'b1;
        send_frame(10, 'h01, 1);
        tick();
        send_frame(5, 'h0B, 1);
        tick();
        check("tog_frames_ok", 32'(fok[0]), 2);
        check("tog_pending_2", 32'(pend[0]), 2);
        k = 0;
        while (expq.size() != 5 && k < 500) begin tick(); k++; end
        check("tog_pending_1", 32'(pend[0]), 1);
        k = 0;
        while (expq.size() != 0 && k < 500) begin tick(); k++; end
        check("tog_pending_0", 32'(pend[0]), 0);
        tog_en = 1'b0;

        // Loss pulses: 1 cycle, 2 cycles, 100 cycles.
        do_reset();
        loss = 1'b1; tick(); loss = 1'b0; tick(); tick();
        check("loss_1", 32'(lev[0]), 1);
        loss = 1'b1; tick(); tick(); loss = 1'b0; tick(); tick();
        check("loss_2", 32'(lev[0]), 2);
        loss = 1'b1;
        repeat (100) tick();
        check("loss_held", 32'(lev[0]), 3);
        loss = 1'b0; tick(); tick();
        check("loss_3", 32'(lev[0]), 3);

        // Reset in mid-frame with in_en still high at release.
        do_reset();
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin en = 1'b1; dat = 8'(8'hA0 + i); tick(); end
        rst = 1'b1;
        tick();
        check("midrst_out_valid", 32'(ov[0]), 0);
        check("midrst_frames_ok", 32'(fok[0]), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin dat = 8'(8'hB0 + i); tick(); end
        en = 1'b0;
        tick(); tick();
        check("ignored_run_dropped", 32'(fdr[0]), 0);
        send_frame(8, 'h50, 1);
        tick();
        check("rearm_frames_ok", 32'(fok[0]), 1);
        check("rearm_frames_dropped", 32'(fdr[0]), 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
